mw_sr_ctrl: RTL and testbench
=============================

Name: mw_sr_ctrl

Overview:
- Front-end controller for the microwave run latch; drives the S/R inputs of the downstream set/reset latch (Q = magnetron on).
- Synchronises and debounces the start button, stop button and door sensor, then edge-detects the buttons.
- Runs a 2-state FSM that emits single-cycle Set/Reset pulses, so S and R are never both asserted and a held button causes exactly one action.
- The timer block's done strobe also ends a run through this block.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a debounced input changes (legal range 2..2^CNT_W-1).
- CNT_W, 5: width of each debounce counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_btn  input  1  raw start button, asynchronous, bouncy, 1 = pressed.
- stop_btn  input  1  raw stop/cancel button, asynchronous, bouncy, 1 = pressed.
- door_open  input  1  raw door sensor, asynchronous, bouncy, 1 = open.
- timer_done  input  1  cooking-timer done strobe, synchronous to clk, not debounced.
- S  output  1  Set pulse to latch, registered, one cycle wide.
- R  output  1  Reset pulse to latch, registered, one cycle wide.
- running  output  1  registered FSM state (1 = RUN); mirrors latch Q.

Behaviour:
- Reset (rst=1 at an edge):
  - S=0, R=0, running=0, FSM=IDLE.
  - Synchroniser flops and debounce counters clear to 0.
  - start_db=0, stop_db=0.
  - door_db=1: the door is treated as open until it is proven closed.
  - rst has priority over every other input.
- Synchroniser: each raw button/door input passes through 2 flops (x_s1, x_s2).
- Debounce, per input:
  - If x_s2==x_db, cnt<=0.
  - Otherwise cnt increments each cycle.
  - When cnt==DEBOUNCE_CYCLES-1 and x_s2!=x_db: x_db<=x_s2 and cnt<=0.
  - Any glitch back to x_db before the count completes restarts the count from 0.
- Edge detect: start_rise = start_db & ~start_db_d and stop_rise = stop_db & ~stop_db_d, where *_d is the db value delayed one cycle.
  - Falling edges cause no action.
- FSM IDLE:
  - Go to RUN with S=1 for one cycle when start_rise & ~door_db & ~stop_db & ~stop_rise.
  - Otherwise stay in IDLE with S=0, R=0.
  - timer_done is ignored in IDLE.
- FSM RUN:
  - Go to IDLE with R=1 for one cycle when stop_rise | door_db | timer_done.
  - Otherwise stay in RUN.
  - start_rise is ignored in RUN, so no repeated S.
- Priority: any stop condition beats start.
  - Simultaneous start_rise and stop_rise in IDLE gives no S.
  - In RUN, stop conditions always win.
- Outputs S, R and running are registered and change on the same edge as the state; running=1 from the edge where S=1.
- Invariant: S & R == 0 on every cycle; S and R are never high for 2 consecutive cycles.
- Latency:
  - A raw input stable from before edge 0 yields x_s2 after edge 1 and x_db after edge 1+DEBOUNCE_CYCLES.
  - S or R is asserted after edge 2+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+3 edges total.
  - timer_done sampled at edge k gives R=1 after edge k.
- Door opening mid-run: R fires once door_db rises. Closing the door again does not restart the run; a new start press is required.
- Reset mid-run: outputs return to 0 immediately and no R pulse is produced. The downstream latch is reset separately by system reset.
- Held start across the end of a run: no new S until the button is released (debounced) and pressed again.

Test Plan:
- Post-reset with door_open=0 held, press start (stable) at cycle 0 → S=1 for exactly 1 cycle DEBOUNCE_CYCLES+3 edges later (19 with default), running=1 thereafter, R=0 throughout.
- Start bounce: toggle start_btn every 5 cycles for 40 cycles, then hold 1 (DEBOUNCE_CYCLES=16) → exactly one S pulse, 19 edges after the final stable edge.
- Door interlock, part 1: with door_open=1 held, press start → no S, running stays 0.
- Door interlock, part 2: in RUN, set door_open=1 → one R pulse 19 edges later and running=0.
- Stop and timer: in RUN, timer_done=1 for 1 cycle → R=1 on the next edge; in a second run, stop press → R after 19 edges; holding stop then pressing start → no S.
- Start and stop debounced-rise on the same cycle in IDLE → S=0, R=0. Holding start through a timer_done end → a single S only, with no re-arm until release and re-press.
- Assert rst mid-RUN for 1 cycle → S=0, R=0, running=0 on the next edge, door_db=1, and a subsequent start is blocked until the door has been debounced closed (16+ cycles).

Source files
------------

// File: rtl/mw_sr_ctrl.sv
// mw_sr_ctrl: front end for the microwave run latch.
// Synchronises and debounces start/stop/door, edge-detects the buttons and
// runs a 2-state FSM that emits single-cycle Set/Reset pulses to the latch.
module mw_sr_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start_btn,
  input  logic stop_btn,
  input  logic door_open,
  input  logic timer_done,
  output logic S,
  output logic R,
  output logic running
);

  // Lane order in the packed vectors: 0 = start, 1 = stop, 2 = door.
  localparam int NUM_IN = 3;
  localparam int L_START = 0;
  localparam int L_STOP  = 1;
  localparam int L_DOOR  = 2;

  // Door reads as open out of reset until it is proven closed.
  localparam logic [NUM_IN-1:0] DB_RST  = 3'b100;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  logic [NUM_IN-1:0]            w_raw;
  logic [NUM_IN-1:0]            r_s1, r_s2, r_db;
  logic [NUM_IN-1:0][CNT_W-1:0] r_cnt;
  logic                         r_start_d, r_stop_d;
  logic                         w_start_rise, w_stop_rise;
  logic                         w_go, w_halt;
  state_t                       r_state;
  logic                         r_s, r_r, r_running;

  assign w_raw = {door_open, stop_btn, start_btn};

  // Two-flop synchronisers plus stable-count debouncers, one lane per input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_db  <= DB_RST;
      r_cnt <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (r_s2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_db[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Delayed debounced buttons for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_d <= 1'b0;
      r_stop_d  <= 1'b0;
    end else begin
      r_start_d <= r_db[L_START];
      r_stop_d  <= r_db[L_STOP];
    end
  end

  assign w_start_rise = r_db[L_START] & ~r_start_d;
  assign w_stop_rise  = r_db[L_STOP]  & ~r_stop_d;

  // Stop conditions always dominate: a held stop or a concurrent stop edge
  // suppresses start, and any stop source ends a run.
  assign w_go   = w_start_rise & ~r_db[L_DOOR] & ~r_db[L_STOP] & ~w_stop_rise;
  assign w_halt = w_stop_rise | r_db[L_DOOR] | timer_done;

  // Run FSM with registered single-cycle S/R pulses and running flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_s       <= 1'b0;
      r_r       <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_s <= 1'b0;
      r_r <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_state   <= ST_RUN;
            r_s       <= 1'b1;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_halt) begin
            r_state   <= ST_IDLE;
            r_r       <= 1'b1;
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign S       = r_s;
  assign R       = r_r;
  assign running = r_running;

endmodule

// File: tb/tb_mw_sr_ctrl.sv
// Directed bench for mw_sr_ctrl with default DEBOUNCE_CYCLES=16:
// a stable raw press gives S (or R) on the 19th edge after the change.
module tb_mw_sr_ctrl;

  logic clk = 1'b0;
  logic rst, start_btn, stop_btn, door_open, timer_done;
  logic S, R, running;

  int n_cmp = 0;
  int n_bad = 0;
  int s_cnt = 0;
  int r_cnt = 0;
  int inv_bad = 0;
  logic prev_s = 1'b0;
  logic prev_r = 1'b0;

  mw_sr_ctrl dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
    .door_open(door_open), .timer_done(timer_done),
    .S(S), .R(R), .running(running)
  );

  always #5 clk = ~clk;

  // One clock; sample 1 time unit after the edge and track pulses/invariant.
  task automatic tick();
    @(posedge clk);
    #1;
    if (S === 1'b1) s_cnt++;
    if (R === 1'b1) r_cnt++;
    if ((S === 1'b1 && R === 1'b1) || (S === 1'b1 && prev_s === 1'b1) ||
        (R === 1'b1 && prev_r === 1'b1))
      inv_bad++;
    prev_s = S;
    prev_r = R;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Edges until S is seen high, -1 if the bound expires.
  task automatic wait_s(input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (S === 1'b1) begin edges = i; break; end
    end
  endtask

  task automatic wait_r(input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (R === 1'b1) begin edges = i; break; end
    end
  endtask

  task automatic end_run_by_timer();
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_btn = 1'b0; stop_btn = 1'b0; door_open = 1'b0; timer_done = 1'b0;
    ticks(3);
    n_cmp++;
    if ({S, R, running} !== 3'b000) begin
      n_bad++; $display("FAIL reset_outputs: got SRrun=%b want 000", {S, R, running});
    end
  endtask

  task automatic test_start_latency();
    int e;
    rst = 1'b0;
    start_btn = 1'b1;
    wait_s(40, e);
    n_cmp++;
    if (e !== 19) begin n_bad++; $display("FAIL start_latency: got %0d edges want 19", e); end
    tick();
    n_cmp++;
    if ({S, R, running} !== 3'b001 || r_cnt !== 0) begin
      n_bad++; $display("FAIL after_start: got SRrun=%b r_cnt=%0d want 001 0", {S, R, running}, r_cnt);
    end
  endtask

  task automatic test_timer_end();
    int e, sb;
    ticks(5);
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    n_cmp++;
    if ({S, R, running} !== 3'b010) begin
      n_bad++; $display("FAIL timer_end: got SRrun=%b want 010", {S, R, running});
    end
    sb = s_cnt;
    ticks(40);
    n_cmp++;
    if (s_cnt !== sb || running !== 1'b0) begin
      n_bad++; $display("FAIL held_start_rearm: got S pulses=%0d running=%b want 0 0", s_cnt - sb, running);
    end
    start_btn = 1'b0;
    ticks(25);
    start_btn = 1'b1;
    wait_s(40, e);
    n_cmp++;
    if (e !== 19) begin n_bad++; $display("FAIL repress_latency: got %0d edges want 19", e); end
  endtask

  task automatic test_stop();
    int e, sb;
    stop_btn = 1'b1;
    wait_r(40, e);
    n_cmp++;
    if (e !== 19 || running !== 1'b0) begin
      n_bad++; $display("FAIL stop_latency: got %0d edges running=%b want 19 0", e, running);
    end
    start_btn = 1'b0;
    ticks(25);
    start_btn = 1'b1;
    sb = s_cnt;
    ticks(40);
    n_cmp++;
    if (s_cnt !== sb || running !== 1'b0) begin
      n_bad++; $display("FAIL stop_held_blocks_start: got S pulses=%0d running=%b want 0 0", s_cnt - sb, running);
    end
    start_btn = 1'b0;
    stop_btn = 1'b0;
    ticks(25);
  endtask

  task automatic test_bounce();
    int e, sb;
    sb = s_cnt;
    for (int i = 0; i < 8; i++) begin
      start_btn = ~start_btn;
      ticks(5);
    end
    start_btn = 1'b1;
    wait_s(60, e);
    n_cmp++;
    if (e !== 19) begin n_bad++; $display("FAIL bounce_latency: got %0d edges want 19", e); end
    ticks(20);
    n_cmp++;
    if (s_cnt - sb !== 1) begin n_bad++; $display("FAIL bounce_pulses: got %0d S pulses want 1", s_cnt - sb); end
    end_run_by_timer();
    start_btn = 1'b0;
    ticks(25);
  endtask

  task automatic test_door();
    int e, sb;
    door_open = 1'b1;
    ticks(25);
    start_btn = 1'b1;
    sb = s_cnt;
    ticks(40);
    n_cmp++;
    if (s_cnt !== sb || running !== 1'b0) begin
      n_bad++; $display("FAIL door_open_blocks: got S pulses=%0d running=%b want 0 0", s_cnt - sb, running);
    end
    start_btn = 1'b0;
    ticks(25);
    door_open = 1'b0;
    ticks(25);
    n_cmp++;
    if (s_cnt !== sb) begin n_bad++; $display("FAIL door_close_no_start: got %0d S pulses want 0", s_cnt - sb); end
    start_btn = 1'b1;
    wait_s(40, e);
    n_cmp++;
    if (e !== 19) begin n_bad++; $display("FAIL door_closed_start: got %0d edges want 19", e); end
    door_open = 1'b1;
    wait_r(40, e);
    n_cmp++;
    if (e !== 19 || running !== 1'b0) begin
      n_bad++; $display("FAIL door_midrun_r: got %0d edges running=%b want 19 0", e, running);
    end
    door_open = 1'b0;
    sb = s_cnt;
    ticks(30);
    n_cmp++;
    if (s_cnt !== sb || running !== 1'b0) begin
      n_bad++; $display("FAIL door_reclose_no_restart: got S pulses=%0d running=%b want 0 0", s_cnt - sb, running);
    end
    start_btn = 1'b0;
    ticks(25);
  endtask

  task automatic test_simultaneous();
    int sb, rb;
    sb = s_cnt; rb = r_cnt;
    start_btn = 1'b1;
    stop_btn = 1'b1;
    ticks(40);
    n_cmp++;
    if (s_cnt !== sb || r_cnt !== rb || running !== 1'b0) begin
      n_bad++; $display("FAIL start_stop_same_cycle: got S=%0d R=%0d running=%b want 0 0 0", s_cnt - sb, r_cnt - rb, running);
    end
    start_btn = 1'b0;
    stop_btn = 1'b0;
    ticks(25);
  endtask

  task automatic test_timer_idle();
    int rb;
    rb = r_cnt;
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    tick();
    n_cmp++;
    if (r_cnt !== rb || running !== 1'b0) begin
      n_bad++; $display("FAIL timer_in_idle: got R pulses=%0d running=%b want 0 0", r_cnt - rb, running);
    end
  endtask

  task automatic test_reset_midrun();
    int e, rb, sb;
    start_btn = 1'b1;
    wait_s(40, e);
    n_cmp++;
    if (e !== 19) begin n_bad++; $display("FAIL pre_reset_start: got %0d edges want 19", e); end
    ticks(3);
    rb = r_cnt;
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({S, R, running} !== 3'b000 || r_cnt !== rb) begin
      n_bad++; $display("FAIL reset_midrun: got SRrun=%b R pulses=%0d want 000 0", {S, R, running}, r_cnt - rb);
    end
    rst = 1'b0;
    // Start still held: its debounced value re-rises after the door clears.
    wait_s(40, e);
    n_cmp++;
    if (e !== 19) begin n_bad++; $display("FAIL post_reset_start: got %0d edges want 19", e); end
    end_run_by_timer();
    start_btn = 1'b0;
    ticks(25);
    // Reset with the door open: start must stay blocked.
    door_open = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_btn = 1'b1;
    sb = s_cnt;
    ticks(40);
    door_open = 1'b0;
    ticks(25);
    n_cmp++;
    if (s_cnt !== sb || running !== 1'b0) begin
      n_bad++; $display("FAIL reset_door_open_blocks: got S pulses=%0d running=%b want 0 0", s_cnt - sb, running);
    end
    start_btn = 1'b0;
    ticks(25);
  endtask

  task automatic test_invariant();
    n_cmp++;
    if (inv_bad !== 0) begin n_bad++; $display("FAIL sr_invariant: got %0d bad cycles want 0", inv_bad); end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_timer_end();
    test_stop();
    test_bounce();
    test_door();
    test_simultaneous();
    test_timer_idle();
    test_reset_midrun();
    test_invariant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
